pipeline_hazard_ctrl: RTL and testbench

//  Sequences the F/D, D/X and X/M pipeline latches and the PC register. Each cycle it drives

---
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - latch-chain control bundle between hazard controller and pipeline
//
// Purpose: carries the pipeline-register instructions and X-stage events into the
// hazard controller, and its enables, clears, state and counters back out.
// Signals:
//   fd_ir, dx_ir         instructions held in the F/D and D/X latches
//   x_mispredict         X stage resolved a branch/jump against the taken guess
//   md_start, md_rdy     mult/div issue this cycle / result valid pulse
//   pc_en, fd_en, dx_en  register/latch write enables
//   fd_clr, dx_clr,      latch clears (insert nop / bubble)
//   xm_clr
//   busy_state           registered controller state (00 RUN, 01 MD_WAIT, 10 FLUSH)
//   stall_cycles         saturating count of cycles with pc_en low
//   flush_events         saturating count of accepted mispredicts
// master: the hazard controller. slave: the pipeline latch chain.
interface pipeline_hazard_ctrl_if;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        x_mispredict;
  logic        md_start;
  logic        md_rdy;
  logic        pc_en;
  logic        fd_en;
  logic        fd_clr;
  logic        dx_en;
  logic        dx_clr;
  logic        xm_clr;
  logic [1:0]  busy_state;
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;

  modport master (
    input  fd_ir, dx_ir, x_mispredict, md_start, md_rdy,
    output pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr,
    output busy_state, stall_cycles, flush_events
  );

  modport slave (
    output fd_ir, dx_ir, x_mispredict, md_start, md_rdy,
    input  pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr,
    input  busy_state, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use / mult-div stall and mispredict flush sequencer
//
// Purpose: drives the PC enable and the F/D, D/X, X/M latch enables/clears each cycle,
// inserting one-cycle load-use stalls, mult/div wait stalls and mispredict flushes,
// and keeps saturating stall-cycle and flush-event counters.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    pipeline_hazard_ctrl_if.master (instructions/events in, controls/status out)
module pipeline_hazard_ctrl #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [4:0]  LW_OP        = 5'b01000,
  parameter logic [4:0]  SW_OP        = 5'b00111,
  parameter logic [4:0]  BNE_OP       = 5'b00010,
  parameter logic [4:0]  BLT_OP       = 5'b00110,
  parameter logic [4:0]  JR_OP        = 5'b00100
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.master  bus
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_WAIT = 2'b01,
    FLUSH   = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   stall_q, stall_d;
  logic [15:0]   flush_q, flush_d;

  logic pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, dx_op, dx_rd;
  logic       fd_rd_src, load_use;
  logic       unused_bits;

  assign fd_op = bus.fd_ir[31:27];
  assign fd_rd = bus.fd_ir[26:22];
  assign fd_rs = bus.fd_ir[21:17];
  assign fd_rt = bus.fd_ir[16:12];
  assign dx_op = bus.dx_ir[31:27];
  assign dx_rd = bus.dx_ir[26:22];
  assign unused_bits = ^{bus.fd_ir[11:0], bus.dx_ir[21:0]};

  // Stores and rd-reading branches/jumps use rd as a source operand.
  assign fd_rd_src = (fd_op == SW_OP) || (fd_op == BNE_OP) ||
                     (fd_op == BLT_OP) || (fd_op == JR_OP);

  assign load_use = (dx_op == LW_OP) && (dx_rd != 5'd0) &&
                    ((dx_rd == fd_rs) || (dx_rd == fd_rt) ||
                     (fd_rd_src && (dx_rd == fd_rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    flush_d = flush_q;
    pc_en   = 1'b1;
    fd_en   = 1'b1;
    fd_clr  = 1'b0;
    dx_en   = 1'b1;
    dx_clr  = 1'b0;
    xm_clr  = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.x_mispredict) begin
          // PC loads the corrected target while the wrong-path F/D and D/X are squashed.
          fd_clr = 1'b1;
          dx_clr = 1'b1;
          if (flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
          end
        end else if (bus.md_start) begin
          // Normal advance lets the unit capture its operands; md_rdy is ignored here.
          state_d = MD_WAIT;
        end else if (load_use) begin
          // Hold F/D and PC, send a bubble into D/X.
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          dx_clr = 1'b1;
        end
      end
      MD_WAIT: begin
        if (bus.md_rdy) begin
          state_d = RUN;
        end else begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          dx_en  = 1'b0;
          xm_clr = 1'b1;
        end
      end
      FLUSH: begin
        fd_clr = 1'b1;
        dx_clr = 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (!pc_en && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;

    // Reset freezes the chain and clears every latch; the registers reset separately.
    if (reset) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      dx_en  = 1'b0;
      fd_clr = 1'b1;
      dx_clr = 1'b1;
      xm_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.fd_en        = fd_en;
  assign bus.fd_clr       = fd_clr;
  assign bus.dx_en        = dx_en;
  assign bus.dx_clr       = dx_clr;
  assign bus.xm_clr       = xm_clr;
  assign bus.busy_state   = state_q;
  assign bus.stall_cycles = stall_q;
  assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES 1 and 3)
module tb_pipeline_hazard_ctrl;
  localparam logic [4:0] LW = 5'b01000, SW = 5'b00111, BNE = 5'b00010, BLT = 5'b00110, JR = 5'b00100;
  // Output vector order: {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr}
  localparam logic [5:0] O_RUN = 6'b110100, O_LU = 6'b000110, O_MD = 6'b000001;
  localparam logic [5:0] O_FL = 6'b111110, O_RST = 6'b001011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mis, mds, mdr;
  logic [31:0] fd_ir, dx_ir;

  pipeline_hazard_ctrl_if i1 ();
  pipeline_hazard_ctrl_if i3 ();

  assign i1.fd_ir = fd_ir;  assign i1.dx_ir = dx_ir;  assign i1.x_mispredict = mis;
  assign i1.md_start = mds; assign i1.md_rdy = mdr;
  assign i3.fd_ir = fd_ir;  assign i3.dx_ir = dx_ir;  assign i3.x_mispredict = mis;
  assign i3.md_start = mds; assign i3.md_rdy = mdr;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .reset(rst), .bus(i1.master));
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .reset(rst), .bus(i3.master));

  wire [5:0] o1 = {i1.pc_en, i1.fd_en, i1.fd_clr, i1.dx_en, i1.dx_clr, i1.xm_clr};
  wire [5:0] o3 = {i3.pc_en, i3.fd_en, i3.fd_clr, i3.dx_en, i3.dx_clr, i3.xm_clr};

  int total = 0;
  int bad = 0;

  // Reference model: pending mult/div flag, remaining flush cycles, plain counters.
  int         m_md[2];
  int         m_fl[2];
  longint     m_stall[2];
  int         m_fev[2];
  int         fc[2] = '{1, 3};
  logic [5:0] exp_o[2];

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt);
    return {op, rd, rs, rt, 12'h000};
  endfunction

  function automatic logic hazard();
    logic [4:0] drd;
    logic [4:0] fop;
    logic       rd_src;
    drd    = dx_ir[26:22];
    fop    = fd_ir[31:27];
    rd_src = (fop == SW) || (fop == BNE) || (fop == BLT) || (fop == JR);
    return (dx_ir[31:27] == LW) && (drd != 5'd0) &&
           ((drd == fd_ir[21:17]) || (drd == fd_ir[16:12]) || (rd_src && (drd == fd_ir[26:22])));
  endfunction

  function automatic logic [5:0] model_out(input int k);
    if (rst) return O_RST;
    if (m_fl[k] > 0) return O_FL;
    if (m_md[k] != 0) return mdr ? O_RUN : O_MD;
    if (mis) return O_FL;
    if (mds) return O_RUN;
    if (hazard()) return O_LU;
    return O_RUN;
  endfunction

  function automatic logic [1:0] exp_busy(input int k);
    if (m_md[k] != 0) return 2'b01;
    if (m_fl[k] > 0) return 2'b10;
    return 2'b00;
  endfunction

  // Apply inputs just after an edge, then move to the falling edge for sampling.
  task automatic drive(input logic r, input logic [31:0] f, d, input logic mi, ms, mr);
    rst = r; fd_ir = f; dx_ir = d; mis = mi; mds = ms; mdr = mr;
    exp_o[0] = model_out(0);
    exp_o[1] = model_out(1);
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_md[k] = 0; m_fl[k] = 0; m_stall[k] = 0; m_fev[k] = 0;
      end else begin
        if (!exp_o[k][5] && m_stall[k] < 64'hFFFF_FFFF) m_stall[k]++;
        if (m_fl[k] > 0) m_fl[k]--;
        else if (m_md[k] != 0) begin
          if (mdr) m_md[k] = 0;
        end else if (mis) begin
          if (m_fev[k] < 65535) m_fev[k]++;
          m_fl[k] = fc[k] - 1;
        end else if (mds) m_md[k] = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 32'h0, 32'h0, 0, 0, 0);
      total++;
      if (o1 !== O_RST || o3 !== O_RST) begin
        bad++; $display("FAIL reset_outputs cyc=%0d got %b/%b want %b", c, o1, o3, O_RST);
      end
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    total++;
    if (o1 !== O_RUN || o3 !== O_RUN || i1.busy_state !== 2'b00 || i3.busy_state !== 2'b00) begin
      bad++; $display("FAIL after_reset got %b/%b busy %b/%b want %b busy 00", o1, o3, i1.busy_state, i3.busy_state, O_RUN);
    end
    total++;
    if (i1.stall_cycles !== 32'd0 || i1.flush_events !== 16'd0 || i3.stall_cycles !== 32'd0 || i3.flush_events !== 16'd0) begin
      bad++; $display("FAIL reset_counters got %0d,%0d/%0d,%0d want 0", i1.stall_cycles, i1.flush_events, i3.stall_cycles, i3.flush_events);
    end
    tick();
  endtask

  task automatic test_load_use();
    longint s0 = m_stall[0];
    drive(0, mk(5'd0, 5'd6, 5'd5, 5'd2), mk(LW, 5'd5, 5'd1, 5'd1), 0, 0, 0);
    total++;
    if (o1 !== O_LU || o3 !== O_LU) begin
      bad++; $display("FAIL load_use_stall got %b/%b want %b", o1, o3, O_LU);
    end
    tick();
    drive(0, mk(5'd0, 5'd6, 5'd5, 5'd2), 32'h0, 0, 0, 0);
    total++;
    if (o1 !== O_RUN || i1.stall_cycles !== 32'(s0 + 1)) begin
      bad++; $display("FAIL load_use_once got %b stall %0d want %b stall %0d", o1, i1.stall_cycles, O_RUN, s0 + 1);
    end
    tick();
    drive(0, mk(5'd0, 5'd6, 5'd0, 5'd2), mk(LW, 5'd0, 5'd1, 5'd1), 0, 0, 0);
    total++;
    if (o1 !== O_RUN) begin
      bad++; $display("FAIL load_r0_no_stall got %b want %b", o1, O_RUN);
    end
    tick();
    drive(0, mk(SW, 5'd5, 5'd1, 5'd2), mk(LW, 5'd5, 5'd1, 5'd1), 0, 0, 0);
    total++;
    if (o1 !== O_LU) begin
      bad++; $display("FAIL store_rd_source got %b want %b", o1, O_LU);
    end
    tick();
    drive(0, mk(5'd0, 5'd5, 5'd1, 5'd2), mk(LW, 5'd5, 5'd1, 5'd1), 0, 0, 0);
    total++;
    if (o1 !== O_RUN) begin
      bad++; $display("FAIL alu_rd_not_source got %b want %b", o1, O_RUN);
    end
    tick();
  endtask

  task automatic test_md_wait();
    longint s0 = m_stall[0];
    int     f0 = m_fev[0];
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    total++;
    if (o1 !== O_RUN) begin bad++; $display("FAIL md_start_advance got %b want %b", o1, O_RUN); end
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(0, 32'h0, 32'h0, 0, 0, 0);
      total++;
      if (o1 !== O_MD || o3 !== O_MD || i1.busy_state !== 2'b01) begin
        bad++; $display("FAIL md_wait_stall cyc=%0d got %b/%b busy %b want %b busy 01", c, o1, o3, i1.busy_state, O_MD);
      end
      tick();
    end
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    total++;
    if (o1 !== O_RUN) begin bad++; $display("FAIL md_rdy_release got %b want %b", o1, O_RUN); end
    tick();
    total++;
    if (i1.busy_state !== 2'b00 || i1.stall_cycles !== 32'(s0 + 6)) begin
      bad++; $display("FAIL md_stall_count got busy %b stall %0d want 00 stall %0d", i1.busy_state, i1.stall_cycles, s0 + 6);
    end
    drive(0, 32'h0, 32'h0, 0, 1, 1);
    tick();
    total++;
    if (i1.busy_state !== 2'b01) begin bad++; $display("FAIL md_rdy_with_start got busy %b want 01", i1.busy_state); end
    drive(0, 32'h0, 32'h0, 1, 0, 0);
    total++;
    if (o1 !== O_MD || o3 !== O_MD) begin bad++; $display("FAIL md_ignores_mispredict got %b/%b want %b", o1, o3, O_MD); end
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    tick();
    total++;
    if (i1.busy_state !== 2'b00 || i1.flush_events !== 16'(f0)) begin
      bad++; $display("FAIL md_exit got busy %b flushes %0d want 00 flushes %0d", i1.busy_state, i1.flush_events, f0);
    end
  endtask

  task automatic test_flush();
    int f1 = m_fev[0];
    int f3 = m_fev[1];
    int n1 = 0;
    int n3 = 0;
    drive(0, mk(5'd0, 5'd6, 5'd5, 5'd2), mk(LW, 5'd5, 5'd0, 5'd0), 1, 0, 0);
    total++;
    if (o1 !== O_FL || o3 !== O_FL) begin bad++; $display("FAIL flush_outputs got %b/%b want %b", o1, o3, O_FL); end
    tick();
    total++;
    if (i1.busy_state !== 2'b00 || i3.busy_state !== 2'b10 ||
        i1.flush_events !== 16'(f1 + 1) || i3.flush_events !== 16'(f3 + 1)) begin
      bad++; $display("FAIL flush_state got busy %b/%b ev %0d/%0d want 00/10 ev %0d/%0d",
                      i1.busy_state, i3.busy_state, i1.flush_events, i3.flush_events, f1 + 1, f3 + 1);
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 32'h0, 32'h0, 0, 0, 0);
      n1 += int'(o1[3]);
      n3 += int'(o3[3]);
      tick();
    end
    total++;
    if (n1 != 0 || n3 != 2) begin bad++; $display("FAIL flush_length extra fd_clr got %0d/%0d want 0/2", n1, n3); end
    drive(0, 32'h0, 32'h0, 1, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 1, 1, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    total++;
    if (i1.flush_events !== 16'(f1 + 3) || i3.flush_events !== 16'(f3 + 2) || i3.busy_state !== 2'b00) begin
      bad++; $display("FAIL flush_ignores_events got ev %0d/%0d busy %b want %0d/%0d busy 00",
                      i1.flush_events, i3.flush_events, i3.busy_state, f1 + 3, f3 + 2);
    end
    tick();
  endtask

  task automatic test_priority();
    longint s0 = m_stall[0];
    drive(0, mk(5'd0, 5'd6, 5'd5, 5'd2), mk(LW, 5'd5, 5'd0, 5'd0), 1, 1, 0);
    total++;
    if (o1 !== O_FL || o3 !== O_FL) begin bad++; $display("FAIL priority_outputs got %b/%b want %b", o1, o3, O_FL); end
    tick();
    total++;
    if (i1.busy_state !== 2'b00 || i1.stall_cycles !== 32'(s0)) begin
      bad++; $display("FAIL priority_no_md got busy %b stall %0d want 00 stall %0d", i1.busy_state, i1.stall_cycles, s0);
    end
    drive(0, 32'h0, 32'h0, 0, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0); tick();
  endtask

  task automatic test_reset_mid_md();
    drive(0, 32'h0, 32'h0, 0, 1, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0); tick();
    drive(1, 32'h0, 32'h0, 0, 0, 0);
    total++;
    if (o1 !== O_RST) begin bad++; $display("FAIL reset_in_md got %b want %b", o1, O_RST); end
    tick();
    total++;
    if (i1.busy_state !== 2'b00 || i1.stall_cycles !== 32'd0 || i3.flush_events !== 16'd0) begin
      bad++; $display("FAIL reset_in_md_state got busy %b stall %0d ev %0d want 00 0 0", i1.busy_state, i1.stall_cycles, i3.flush_events);
    end
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    total++;
    if (o1 !== O_RUN || i1.busy_state !== 2'b00 || i1.stall_cycles !== 32'd0) begin
      bad++; $display("FAIL late_md_rdy got %b busy %b stall %0d want %b 00 0", o1, i1.busy_state, i1.stall_cycles, O_RUN);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      logic [31:0] f, d;
      f = mk(($urandom_range(3) == 0) ? SW : 5'($urandom_range(7)),
             5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      d = mk(($urandom_range(1) == 0) ? LW : 5'($urandom_range(7)),
             5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
      drive(($urandom_range(49) == 0), f, d, ($urandom_range(9) == 0),
            ($urandom_range(9) == 0), ($urandom_range(3) == 0));
      total++;
      if (o1 !== exp_o[0] || o3 !== exp_o[1]) begin
        bad++; $display("FAIL random_outputs cyc=%0d got %b/%b want %b/%b", c, o1, o3, exp_o[0], exp_o[1]);
      end
      tick();
      total++;
      if (i1.busy_state !== exp_busy(0) || i3.busy_state !== exp_busy(1) ||
          i1.stall_cycles !== 32'(m_stall[0]) || i3.stall_cycles !== 32'(m_stall[1]) ||
          i1.flush_events !== 16'(m_fev[0]) || i3.flush_events !== 16'(m_fev[1])) begin
        bad++; $display("FAIL random_state cyc=%0d got busy %b/%b stall %0d/%0d ev %0d/%0d want %b/%b %0d/%0d %0d/%0d",
                        c, i1.busy_state, i3.busy_state, i1.stall_cycles, i3.stall_cycles,
                        i1.flush_events, i3.flush_events, exp_busy(0), exp_busy(1),
                        m_stall[0], m_stall[1], m_fev[0], m_fev[1]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_md[k] = 0; m_fl[k] = 0; m_stall[k] = 0; m_fev[k] = 0; exp_o[k] = O_RST;
    end
    rst = 1'b1; fd_ir = '0; dx_ir = '0; mis = 1'b0; mds = 1'b0; mdr = 1'b0;
    test_reset();
    test_load_use();
    test_md_wait();
    test_flush();
    test_priority();
    test_reset_mid_md();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
